// File: rtl/rram_cmd_sequencer.sv
// Command sequencer for the RRAM array: turns latched host commands plus
// address/data nibbles into single-cycle array strobes, and reports ready/busy and status.
module rram_cmd_sequencer #(
  parameter int ADDR_NIBBLES = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                command,
  input  logic                      command_register_ready,
  input  logic                      ALE,
  input  logic                      DIN_valid,
  input  logic [3:0]                IO_in,
  input  logic                      RE,
  output logic [3:0]                IO_out,
  output logic                      IO_out_valid,
  output logic [4*ADDR_NIBBLES-1:0] array_addr,
  output logic [7:0]                array_wdata,
  output logic                      array_we,
  output logic                      array_re,
  input  logic [7:0]                array_rdata,
  input  logic                      array_done,
  output logic                      R_B,
  output logic [3:0]                status
);

  localparam int AW = 4 * ADDR_NIBBLES;
  localparam logic [3:0] CMD_READ   = 4'b0001;
  localparam logic [3:0] CMD_WRITE  = 4'b0010;
  localparam logic [3:0] CMD_STATUS = 4'b0111;
  localparam logic [3:0] CMD_RESET  = 4'b1111;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DIN, S_EXEC, S_DOUT} state_t;

  state_t          state, state_d;
  logic            rdy_q;
  logic            cmd_edge;
  logic            is_read, is_read_d;
  logic [7:0]      nib_cnt, nib_cnt_d;
  logic [15:0]     cnt, cnt_d;
  logic [AW-1:0]   addr_d;
  logic [7:0]      wdata_d;
  logic            we_d, re_d;
  logic [3:0]      io_out_d, low_nib, low_nib_d;
  logic            io_valid_d;
  logic            fail, fail_d, illegal, illegal_d;

  assign cmd_edge = command_register_ready & ~rdy_q;
  assign R_B      = (state != S_EXEC);
  assign status   = {1'b0, R_B, illegal, fail};

  always_comb begin
    state_d    = state;
    is_read_d  = is_read;
    nib_cnt_d  = nib_cnt;
    cnt_d      = cnt;
    addr_d     = array_addr;
    wdata_d    = array_wdata;
    we_d       = 1'b0;
    re_d       = 1'b0;
    io_out_d   = IO_out;
    io_valid_d = IO_out_valid;
    low_nib_d  = low_nib;
    fail_d     = fail;
    illegal_d  = illegal;

    // RESET aborts anything; other commands are only honoured outside EXEC
    if (cmd_edge && command == CMD_RESET) begin
      state_d    = S_IDLE;
      io_valid_d = 1'b0;
      fail_d     = 1'b0;
      illegal_d  = 1'b0;
      cnt_d      = '0;
    end else if (cmd_edge && state != S_EXEC) begin
      case (command)
        CMD_READ, CMD_WRITE: begin
          state_d    = S_ADDR;
          is_read_d  = (command == CMD_READ);
          nib_cnt_d  = '0;
          io_valid_d = 1'b0;
          fail_d     = 1'b0;
          illegal_d  = 1'b0;
        end
        CMD_STATUS: begin
          state_d    = S_IDLE;
          io_out_d   = status;
          io_valid_d = 1'b1;
          fail_d     = 1'b0;
          illegal_d  = 1'b0;
        end
        default: illegal_d = 1'b1;
      endcase
    end else begin
      case (state)
        S_IDLE: if (RE && IO_out_valid) io_valid_d = 1'b0;
        S_ADDR: if (ALE) begin
          addr_d = AW'({array_addr, IO_in});
          if (nib_cnt == 8'(ADDR_NIBBLES - 1)) begin
            nib_cnt_d = '0;
            cnt_d     = '0;
            if (is_read) begin
              state_d = S_EXEC;
              re_d    = 1'b1;
            end else begin
              state_d = S_DIN;
            end
          end else begin
            nib_cnt_d = nib_cnt + 8'd1;
          end
        end
        S_DIN: if (DIN_valid) begin
          wdata_d = {array_wdata[3:0], IO_in};
          if (nib_cnt == 8'd1) begin
            state_d   = S_EXEC;
            we_d      = 1'b1;
            cnt_d     = '0;
            nib_cnt_d = '0;
          end else begin
            nib_cnt_d = 8'd1;
          end
        end
        // completion beats a timeout landing in the same cycle
        S_EXEC: if (array_done) begin
          if (is_read) begin
            state_d    = S_DOUT;
            io_out_d   = array_rdata[7:4];
            low_nib_d  = array_rdata[3:0];
            io_valid_d = 1'b1;
            nib_cnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
        S_DOUT: if (RE && IO_out_valid) begin
          if (nib_cnt == 8'd0) begin
            io_out_d  = low_nib;
            nib_cnt_d = 8'd1;
          end else begin
            io_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // rdy_q follows the ready level even in reset so a held level is not an edge
  always_ff @(posedge clk) begin
    rdy_q <= command_register_ready;
    if (rst) begin
      state        <= S_IDLE;
      is_read      <= 1'b0;
      nib_cnt      <= '0;
      cnt          <= '0;
      array_addr   <= '0;
      array_wdata  <= '0;
      array_we     <= 1'b0;
      array_re     <= 1'b0;
      IO_out       <= '0;
      IO_out_valid <= 1'b0;
      low_nib      <= '0;
      fail         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      state        <= state_d;
      is_read      <= is_read_d;
      nib_cnt      <= nib_cnt_d;
      cnt          <= cnt_d;
      array_addr   <= addr_d;
      array_wdata  <= wdata_d;
      array_we     <= we_d;
      array_re     <= re_d;
      IO_out       <= io_out_d;
      IO_out_valid <= io_valid_d;
      low_nib      <= low_nib_d;
      fail         <= fail_d;
      illegal      <= illegal_d;
    end
  end

endmodule
